// File: rtl/core_pkg.sv
// Shared RV32I core constants and types used by the fetch stage.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ResetVectorDefault = 32'h0000_0000;
  localparam logic [XLEN-1:0] NopInstr           = 32'h0000_0013;
  localparam logic [XLEN-1:0] PcIncr             = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, decoder and control.
interface fetch_unit_if;
  import core_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] pc_out;
  logic            ir_valid;
  logic            ir_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            halted;

  modport master (
    output imem_req, imem_addr, ir, pc_out, ir_valid, halted,
    input  imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, ir, pc_out, ir_valid, halted,
    output imem_rvalid, imem_rdata, ir_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue with flush; head and count come straight from registers.
module fetch_fifo
  import core_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         head_valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_i) begin
            head_d  = push_data_i;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop_ok) begin
            head_d = push_data_i;
          end else if (push_i) begin
            tail_d  = push_data_i;
            count_d = 2'd2;
          end else if (pop_ok) begin
            count_d = 2'd0;
          end
        end
        default: begin
          // Full: tail shifts to head; the issue logic never pushes here without a pop.
          if (pop_ok) begin
            head_d = tail_q;
            if (push_i) tail_d = push_data_i;
            else        count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, single-outstanding imem requests, redirect/halt flush.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = ResetVectorDefault
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic            outst_q, outst_d, drop_q, drop_d, halted_q, halted_d;
  logic            flush, resp, push, pop, issue;
  logic [1:0]      fifo_count, count_after;
  fetch_entry_t    push_entry, head;

  always_comb begin
    flush       = !halted_q && (bus.halt || bus.redirect);
    resp        = rst_n && bus.imem_rvalid;
    push        = resp && !drop_q && !flush;
    pop         = bus.ir_valid && bus.ir_ready && !flush;
    push_entry  = '{pc: req_pc_q, instr: bus.imem_rdata};
    count_after = fifo_count + {1'b0, push} - {1'b0, pop};
    // Only one request may be in flight, and it must have a free slot when it returns.
    issue = rst_n && !halted_q && !bus.halt && !bus.redirect && !drop_q &&
            (!outst_q || resp) && (count_after < 2'd2);

    outst_d  = issue || (outst_q && !resp);
    halted_d = halted_q || bus.halt;
    req_pc_d = issue ? fetch_pc_q : req_pc_q;

    // A response arriving in the flush cycle is the stale one, so no drop is needed.
    drop_d = drop_q;
    if (resp)                 drop_d = 1'b0;
    else if (flush && outst_q) drop_d = 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (flush && !bus.halt) fetch_pc_d = bus.redirect_pc & ~32'h3;
    else if (issue)         fetch_pc_d = fetch_pc_q + PcIncr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= '0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (bus.ir_valid),
    .count_o      (fifo_count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = issue ? fetch_pc_q : '0;
  assign bus.ir        = head.instr;
  assign bus.pc_out    = head.pc;
  assign bus.halted    = halted_q;

  a_rvalid_has_req : assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency instruction memory model.
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   lat = 1;
  logic pend;
  int   cnt;
  logic [31:0] pend_addr;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory with `lat` cycles from request to rvalid; reset shared with the DUT.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend            <= 1'b0;
      cnt             <= 0;
      pend_addr       <= '0;
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (bus.imem_req) begin
        if (lat == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(bus.imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= bus.imem_addr;
          cnt       <= lat - 1;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(pend_addr);
          pend            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat   = l;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.ir_ready = 1'b1; bus.redirect = 1'b0; bus.halt = 1'b0; bus.redirect_pc = '0;
    rst_n = 1'b0;
    step();
    step();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    nvec++; if (bus.imem_addr !== 32'h0) begin nerr++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
    nvec++; if (bus.ir !== 32'h0) begin nerr++; $display("FAIL reset_ir got %h want 0", bus.ir); end
    nvec++; if (bus.pc_out !== 32'h0) begin nerr++; $display("FAIL reset_pc got %h want 0", bus.pc_out); end
    nvec++; if (bus.ir_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus.ir_valid); end
    nvec++; if (bus.halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b want 0", bus.halted); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    lat   = 1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      ea = 32'(4 * k);
      nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== ea) begin
        nerr++; $display("FAIL stream_req c%0d got %b/%h want 1/%h", k, bus.imem_req, bus.imem_addr, ea);
      end
      if (k >= 2) begin
        ep = 32'(4 * (k - 2));
        nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== ep || bus.ir !== mem_word(ep)) begin
          nerr++; $display("FAIL stream_out c%0d got %b/%h/%h want 1/%h/%h", k, bus.ir_valid,
                           bus.pc_out, bus.ir, ep, mem_word(ep));
        end
      end else begin
        nvec++; if (bus.ir_valid !== 1'b0) begin nerr++; $display("FAIL stream_early c%0d got %b want 0", k, bus.ir_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    bus.ir_ready = 1'b0;
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      if (bus.imem_req === 1'b1) nreq++;
      if (k == 4) begin
        nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h0) begin
          nerr++; $display("FAIL bp_head got %b/%h want 1/0", bus.ir_valid, bus.pc_out);
        end
      end
      step();
    end
    nvec++; if (nreq != 2) begin nerr++; $display("FAIL bp_nreq got %0d want 2", nreq); end
    bus.ir_ready = 1'b1;
    #1;
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      nerr++; $display("FAIL bp_resume got %b/%h want 1/8", bus.imem_req, bus.imem_addr);
    end
    nvec++; if (bus.pc_out !== 32'h0) begin nerr++; $display("FAIL bp_drain0 got %h want 0", bus.pc_out); end
    step();
    nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h4) begin
      nerr++; $display("FAIL bp_drain1 got %b/%h want 1/4", bus.ir_valid, bus.pc_out);
    end
    step();
    nvec++; if (bus.pc_out !== 32'h8 || bus.ir !== mem_word(32'h8)) begin
      nerr++; $display("FAIL bp_drain2 got %h/%h want 8/%h", bus.pc_out, bus.ir, mem_word(32'h8));
    end
  endtask

  task automatic test_redirect_drop();
    bit seen = 1'b0;
    bus.ir_ready = 1'b1;
    do_reset(3);
    step(); step(); step();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      nerr++; $display("FAIL rd_req4 got %b/%h want 1/4", bus.imem_req, bus.imem_addr);
    end
    step();
    nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h0) begin
      nerr++; $display("FAIL rd_head got %b/%h want 1/0", bus.ir_valid, bus.pc_out);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    #1;
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rd_noreq0 got %b want 0", bus.imem_req); end
    step();
    bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      nerr++; $display("FAIL rd_flush got %b/%b want 0/0", bus.ir_valid, bus.imem_req);
    end
    step();
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rd_noreq2 got %b want 0", bus.imem_req); end
    step();
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      nerr++; $display("FAIL rd_target got %b/%h want 1/100", bus.imem_req, bus.imem_addr);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (bus.ir_valid === 1'b1) seen = 1'b1;
    end
    nvec++; if (!seen) begin
      nerr++; $display("FAIL rd_timeout got no ir_valid want ir_valid within 10 cycles");
    end else if (bus.pc_out !== 32'h100 || bus.ir !== mem_word(32'h100)) begin
      nerr++; $display("FAIL rd_deliver got %h/%h want 100/%h", bus.pc_out, bus.ir, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid();
    bus.ir_ready = 1'b1;
    do_reset(1);
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    #1;
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rr_noreq got %b want 0", bus.imem_req); end
    step();
    bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.ir_valid !== 1'b0) begin
      nerr++; $display("FAIL rr_target got %b/%h/%b want 1/200/0", bus.imem_req, bus.imem_addr, bus.ir_valid);
    end
    step();
    nvec++; if (bus.ir_valid !== 1'b0) begin nerr++; $display("FAIL rr_discard got %b want 0", bus.ir_valid); end
    step();
    nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h200) begin
      nerr++; $display("FAIL rr_deliver got %b/%h want 1/200", bus.ir_valid, bus.pc_out);
    end
  endtask

  task automatic test_halt();
    int nreq = 0;
    int nval = 0;
    bus.ir_ready = 1'b1;
    do_reset(1);
    step(); step(); step();
    nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h4) begin
      nerr++; $display("FAIL halt_pre got %b/%h want 1/4", bus.ir_valid, bus.pc_out);
    end
    bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    #1;
    nvec++; if (bus.imem_req !== 1'b0 || bus.halted !== 1'b0) begin
      nerr++; $display("FAIL halt_cycle got %b/%b want 0/0", bus.imem_req, bus.halted);
    end
    step();
    bus.halt = 1'b0; bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1) begin
      nerr++; $display("FAIL halt_next got %b/%b want 0/1", bus.ir_valid, bus.halted);
    end
    for (int k = 0; k < 20; k++) begin
      if (bus.imem_req === 1'b1) nreq++;
      if (bus.ir_valid === 1'b1) nval++;
      step();
    end
    nvec++; if (nreq != 0 || nval != 0) begin
      nerr++; $display("FAIL halt_quiet got %0d req/%0d valid want 0/0", nreq, nval);
    end
    nvec++; if (bus.halted !== 1'b1) begin nerr++; $display("FAIL halt_sticky got %b want 1", bus.halted); end
  endtask

  task automatic test_reset_mid();
    bus.ir_ready = 1'b1;
    do_reset(1);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    nvec++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.ir_valid !== 1'b0) begin
      nerr++; $display("FAIL rm_ctrl got %b/%h/%b want 0/0/0", bus.imem_req, bus.imem_addr, bus.ir_valid);
    end
    nvec++; if (bus.ir !== 32'h0 || bus.pc_out !== 32'h0 || bus.halted !== 1'b0) begin
      nerr++; $display("FAIL rm_data got %h/%h/%b want 0/0/0", bus.ir, bus.pc_out, bus.halted);
    end
    rst_n = 1'b1;
    #1;
    nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      nerr++; $display("FAIL rm_restart got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    step(); step();
    nvec++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h0 || bus.ir !== mem_word(32'h0)) begin
      nerr++; $display("FAIL rm_deliver got %b/%h/%h want 1/0/%h", bus.ir_valid, bus.pc_out, bus.ir,
                       mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_rvalid();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
